seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one hex-to-segment decoder. It accepts a packed hex value through a valid/ready handshake and double-buffers it, committing new values only at frame boundaries so the display never tears. Each frame it steps through the digits, inserting a blanking guard between digits to suppress ghosting. It drives the shared decoder's 4-bit nibble input, a blank request, and the per-digit select lines.

---
 rtl/seg7_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Purpose : time-multiplexed scan controller for common-anode 7-seg digits sharing one decoder.
// Latency : accepted iDATA is committed at the next frame boundary, shown from the following frame.
// Backpres: oREADY drops the cycle after a transfer and rises the cycle after the frame-boundary commit.
//
// Ports:
//   iCLK, iRST   clock (rising edge) and asynchronous active-high reset
//   iDATA        packed hex value, nibble k -> digit k
//   iVALID       iDATA valid; transfer on iVALID & oREADY
//   oREADY       registered, = !pending
//   oDIG         nibble for the shared hex decoder (registered)
//   oDIG_SEL     active-low digit selects, one-hot or all-high (registered)
//   oBLANK       force decoder segments off (registered)
//   oFRAME       one-cycle pulse in the first guard cycle of digit 0 (registered)
//
// Optional build macro: SEG7_LZ_SUPPRESS_EN enables leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic [4*NUM_DIGITS-1:0] iDATA,
    input  logic                    iVALID,
    output logic                    oREADY,
    output logic [3:0]              oDIG,
    output logic [NUM_DIGITS-1:0]   oDIG_SEL,
    output logic                    oBLANK,
    output logic                    oFRAME
);

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW      = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        GUARD = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DW-1:0]         active_q, active_d;
    logic [DW-1:0]         shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  ready_q, ready_d;
    logic [3:0]            dig_q, dig_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  blank_q, blank_d;
    logic                  frame_q, frame_d;

    logic                  xfer;
    logic [3:0]            cur_nib;
    logic [NUM_DIGITS-1:0] cur_sel_n;
    logic                  lit;

    // ready_q always mirrors !pending_q, so a transfer can never coincide
    // with a commit that consumes a pending value.
    assign xfer = iVALID && ready_q;

    // Nibble and active-low select for the digit about to be lit.
    always_comb begin
        cur_nib   = 4'h0;
        cur_sel_n = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib      = active_q[4*k +: 4];
                cur_sel_n[k] = 1'b0;
            end
        end
    end

`ifdef SEG7_LZ_SUPPRESS_EN
    // A digit k>0 stays dark when it and every more-significant nibble are
    // zero; digit 0 is always lit so a zero value still shows "0".
    always_comb begin
        lit = 1'b1;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if ((idx_q == IW'(k)) && ((active_q >> (4*k)) == '0)) begin
                lit = 1'b0;
            end
        end
    end
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        idx_d     = idx_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        dig_d     = dig_q;
        sel_d     = sel_q;
        blank_d   = blank_q;
        frame_d   = 1'b0;

        case (state_q)
            GUARD: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DWELL;
                    cnt_d   = '0;
                    dig_d   = cur_nib;
                    if (lit) begin
                        sel_d   = cur_sel_n;
                        blank_d = 1'b0;
                    end else begin
                        sel_d   = '1;
                        blank_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    sel_d   = '1;
                    blank_d = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        // Frame boundary: the only point where active may
                        // change, so a frame never mixes old and new nibbles.
                        idx_d   = '0;
                        frame_d = 1'b1;
                        if (pending_q) begin
                            active_d  = shadow_q;
                            pending_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
            end
        endcase

        if (xfer) begin
            shadow_d  = iDATA;
            pending_d = 1'b1;
        end

        ready_d = !pending_d;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= GUARD;
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            dig_q     <= 4'h0;
            sel_q     <= '1;
            blank_q   <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            dig_q     <= dig_d;
            sel_q     <= sel_d;
            blank_q   <= blank_d;
            frame_q   <= frame_d;
        end
    end

    assign oREADY   = ready_q;
    assign oDIG     = dig_q;
    assign oDIG_SEL = sel_q;
    assign oBLANK   = blank_q;
    assign oFRAME   = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Purpose : self-checking bench for seg7_scan_ctrl (4 digits, dwell 4, guard 2).
// Latency : reference model predicts every output on every cycle from frame-position arithmetic.
// Backpres: model tracks pending/shadow/active as plain values; transfers follow iVALID & !pending.
module tb_seg7_scan_ctrl;

    localparam int ND    = 4;
    localparam int DWC   = 4;
    localparam int BLC   = 2;
    localparam int SLOT  = DWC + BLC;
    localparam int FRAME = ND * SLOT;

`ifdef SEG7_LZ_SUPPRESS_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [15:0] iDATA;
    logic        iVALID;
    logic        oREADY;
    logic [3:0]  oDIG;
    logic [3:0]  oDIG_SEL;
    logic        oBLANK;
    logic        oFRAME;

    always #5 iCLK = ~iCLK;

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DWC),
        .BLANK_CYCLES(BLC)
    ) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iDATA   (iDATA),
        .iVALID  (iVALID),
        .oREADY  (oREADY),
        .oDIG    (oDIG),
        .oDIG_SEL(oDIG_SEL),
        .oBLANK  (oBLANK),
        .oFRAME  (oFRAME)
    );

    int          tests = 0;
    int          fails = 0;
    int          c;           // cycle index since reset release
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pending;

    typedef struct {
        logic [15:0] data;
        int          pos;        // frame position of the write cycle
        int          waitf;      // frame starts to pass before new data shows
        logic [15:0] exp_dig;    // nibble k = oDIG on digit k
        logic [15:0] exp_sel;    // nibble k = oDIG_SEL on digit k
        logic [3:0]  exp_blank;  // bit k = oBLANK on digit k
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    task automatic model_reset();
        c         = 0;
        m_active  = 16'h0;
        m_shadow  = 16'h0;
        m_pending = 1'b0;
    endtask

    task automatic check_cycle();
        int         p;
        int         k;
        bit         dwell;
        bit         lit;
        logic [3:0] esel;
        p     = c % FRAME;
        k     = p / SLOT;
        dwell = (p % SLOT) >= BLC;
        lit   = !LZ || (k == 0) || ((m_active >> (4*k)) != 16'h0);
        esel  = 4'hF;
        if (dwell && lit) esel[k] = 1'b0;
        chk("ready", 16'(oREADY), 16'(!m_pending));
        chk("frame", 16'(oFRAME), 16'((p == 0) && (c != 0)));
        chk("sel",   16'(oDIG_SEL), 16'(esel));
        chk("blank", 16'(oBLANK), 16'(!(dwell && lit)));
        if (dwell) chk("dig", 16'(oDIG), 16'(m_active[4*k +: 4]));
    endtask

    task automatic tick(input bit vld, input logic [15:0] d);
        bit xfer;
        iVALID = vld;
        iDATA  = d;
        @(posedge iCLK);
        xfer = vld && !m_pending;
        if (((c % FRAME) == FRAME - 1) && m_pending) begin
            m_active  = m_shadow;
            m_pending = 1'b0;
        end
        if (xfer) begin
            m_shadow  = d;
            m_pending = 1'b1;
        end
        c++;
        #1;
        check_cycle();
        iVALID = 1'b0;
    endtask

    task automatic advance_to(input int pos);
        int n;
        n = 0;
        while (((c % FRAME) != pos) && (n < 2*FRAME)) begin
            tick(1'b0, 16'h0);
            n++;
        end
    endtask

    task automatic check_digits(input string name, input logic [15:0] ed,
                                input logic [15:0] es, input logic [3:0] eb);
        for (int k = 0; k < ND; k++) begin
            advance_to(k*SLOT + BLC);
            chk({name, "_dig"},   16'(oDIG),     16'(ed[4*k +: 4]));
            chk({name, "_sel"},   16'(oDIG_SEL), 16'(es[4*k +: 4]));
            chk({name, "_blank"}, 16'(oBLANK),   16'(eb[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        int n;
        bit vld;
        logic [15:0] d;

        tbl[0] = '{16'h1234,  5, 1, 16'h1234, 16'h7BDE, 4'b0000};
        tbl[4] = '{16'h8000, 20, 1, 16'h8000, 16'h7BDE, 4'b0000};
`ifdef SEG7_LZ_SUPPRESS_EN
        tbl[1] = '{16'h00F1, 23, 2, 16'h00F1, 16'hFFDE, 4'b1100};
        tbl[2] = '{16'h0050,  9, 1, 16'h0050, 16'hFFDE, 4'b1100};
        tbl[3] = '{16'h0000, 13, 1, 16'h0000, 16'hFFFE, 4'b1110};
`else
        tbl[1] = '{16'h00F1, 23, 2, 16'h00F1, 16'h7BDE, 4'b0000};
        tbl[2] = '{16'h0050,  9, 1, 16'h0050, 16'h7BDE, 4'b0000};
        tbl[3] = '{16'h0000, 13, 1, 16'h0000, 16'h7BDE, 4'b0000};
`endif

        // Reset and idle scan: guard/dwell sequence and 24-cycle period.
        model_reset();
        iRST   = 1'b1;
        iVALID = 1'b0;
        iDATA  = 16'h0;
        repeat (2) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        check_cycle();
        chk("reset_dig", 16'(oDIG), 16'h0);
        repeat (2*FRAME) tick(1'b0, 16'h0);

        // Table: write at a given frame position, then check the frame that shows it.
        for (int i = 0; i < 5; i++) begin
            advance_to(tbl[i].pos);
            chk("wr_ready", 16'(oREADY), 16'h1);
            tick(1'b1, tbl[i].data);
            seen = ((c % FRAME) == 0) ? 1 : 0;
            while (seen < tbl[i].waitf) begin
                tick(1'b0, 16'h0);
                if ((c % FRAME) == 0) seen++;
            end
            check_digits($sformatf("tbl%0d", i), tbl[i].exp_dig, tbl[i].exp_sel, tbl[i].exp_blank);
        end

        // Held valid: ABCD accepted, 5678 waits until the cycle after the commit.
        advance_to(7);
        tick(1'b1, 16'hABCD);
        n = 0;
        while ((oREADY !== 1'b1) && (n < 3*FRAME)) begin
            tick(1'b1, 16'h5678);
            n++;
        end
        chk("hold_accept_pos", 16'(c % FRAME), 16'd0);
        tick(1'b1, 16'h5678);
        check_digits("hold_a", 16'hABCD, 16'h7BDE, 4'b0000);
        advance_to(0);
        check_digits("hold_b", 16'h5678, 16'h7BDE, 4'b0000);

        // Random traffic against the model.
        repeat (500) begin
            vld = ($urandom_range(0, 3) == 0);
            d   = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       d = d & 16'h000F;
                1:       d = d & 16'h00FF;
                2:       d = d & 16'h0FFF;
                default: d = d;
            endcase
            tick(vld, d);
        end

        // Async reset mid-dwell of digit 2 with a write pending.
        advance_to(0);
        advance_to(12);
        tick(1'b1, 16'h9999);
        advance_to(15);
        iRST = 1'b1;
        #2;
        chk("arst_sel",   16'(oDIG_SEL), 16'hF);
        chk("arst_blank", 16'(oBLANK),   16'h1);
        chk("arst_ready", 16'(oREADY),   16'h1);
        chk("arst_frame", 16'(oFRAME),   16'h0);
        chk("arst_dig",   16'(oDIG),     16'h0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        model_reset();
        check_cycle();
        repeat (FRAME + 6) tick(1'b0, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
